// File: rtl/otbn_insn_prefetch.sv
// Speculative OTBN instruction prefetch stage: predicts the next Imem address from
// sequential flow and the loop-stack preview, and checks fetched-word integrity.
`timescale 1ns/1ps
module otbn_insn_prefetch #(
  parameter int unsigned ImemAddrWidth = 12,
  parameter int unsigned ImemDataWidth = 39
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  output logic                     imem_req_o,
  output logic [ImemAddrWidth-1:0] imem_addr_o,
  input  logic [ImemDataWidth-1:0] imem_rdata_i,
  input  logic                     imem_rvalid_i,

  input  logic                     insn_fetch_req_valid_i,
  input  logic [ImemAddrWidth-1:0] insn_fetch_req_addr_i,
  output logic                     insn_fetch_resp_valid_o,
  output logic [ImemAddrWidth-1:0] insn_fetch_resp_addr_o,
  output logic [31:0]              insn_fetch_resp_data_o,
  output logic                     insn_fetch_err_o,

  input  logic                     prefetch_loop_active_i,
  input  logic [31:0]              prefetch_loop_iterations_i,
  input  logic [ImemAddrWidth:0]   prefetch_loop_end_addr_i,
  input  logic [ImemAddrWidth-1:0] prefetch_loop_jump_addr_i,

  input  logic                     stall_i,
  input  logic                     clear_i
);

  localparam int unsigned InsnWidth = 32;
  localparam int unsigned SynWidth  = 7;
  localparam logic [ImemAddrWidth-1:0] InsnBytes = ImemAddrWidth'(4);
  localparam logic [ImemDataWidth-1:0] InvMask   = ImemDataWidth'(39'h2A00000000);

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e                   state_q, state_d;
  logic [ImemAddrWidth-1:0] pf_addr_q, pf_addr_d;
  logic [ImemAddrWidth-1:0] req_addr_q, req_addr_d;
  logic                     req_valid_q, req_valid_d;

  logic                     hit;
  logic                     flush;
  logic                     loop_end_hit;
  logic [ImemAddrWidth-1:0] pred_addr;
  logic [ImemDataWidth-1:0] code_word;
  logic [SynWidth-1:0]      syndrome;
  logic                     err_single;
  logic                     err_double;

  // Inverted-SECDED (39,32) syndrome check on the returned word.
  always_comb begin
    code_word   = imem_rdata_i ^ InvMask;
    syndrome[0] = ^(code_word & ImemDataWidth'(39'h012606BD25));
    syndrome[1] = ^(code_word & ImemDataWidth'(39'h02DEBA8050));
    syndrome[2] = ^(code_word & ImemDataWidth'(39'h04413D89AA));
    syndrome[3] = ^(code_word & ImemDataWidth'(39'h0831234ED1));
    syndrome[4] = ^(code_word & ImemDataWidth'(39'h10C2C1323B));
    syndrome[5] = ^(code_word & ImemDataWidth'(39'h202DCC624C));
    syndrome[6] = ^(code_word & ImemDataWidth'(39'h4098505586));
    err_single  = ^syndrome;
    err_double  = (|syndrome) & ~err_single;
  end

  // Prediction uses only registered state and loop preview, never the core's request address.
  always_comb begin
    loop_end_hit = prefetch_loop_active_i &
                   ({1'b0, pf_addr_q} == prefetch_loop_end_addr_i) &
                   (prefetch_loop_iterations_i > 32'd1);
    if (stall_i) begin
      pred_addr = pf_addr_q;
    end else if (loop_end_hit) begin
      pred_addr = prefetch_loop_jump_addr_i;
    end else begin
      pred_addr = pf_addr_q + InsnBytes;
    end
  end

  assign flush = rst_i | clear_i;
  assign hit   = (state_q == StRun) & req_valid_q & (req_addr_q == pf_addr_q) & imem_rvalid_i;

  assign insn_fetch_resp_addr_o = pf_addr_q;
  assign insn_fetch_resp_data_o = imem_rdata_i[InsnWidth-1:0];

  always_comb begin
    state_d                 = state_q;
    pf_addr_d               = pf_addr_q;
    req_addr_d              = insn_fetch_req_addr_i;
    req_valid_d             = insn_fetch_req_valid_i;
    imem_req_o              = 1'b0;
    imem_addr_o             = '0;
    insn_fetch_resp_valid_o = hit;
    insn_fetch_err_o        = hit & (err_single | err_double);

    unique case (state_q)
      StIdle: begin
        if (insn_fetch_req_valid_i) begin
          imem_req_o  = 1'b1;
          imem_addr_o = insn_fetch_req_addr_i;
          pf_addr_d   = insn_fetch_req_addr_i;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (!insn_fetch_req_valid_i) begin
          state_d = StIdle;
        end else begin
          imem_req_o = 1'b1;
          if (hit) begin
            imem_addr_o = pred_addr;
          end else if (req_valid_q) begin
            // Mispredict or dropped read: refetch what the core actually asked for.
            imem_addr_o = req_addr_q;
          end else begin
            imem_addr_o = pf_addr_q;
          end
          pf_addr_d = imem_addr_o;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d                 = StIdle;
      pf_addr_d               = '0;
      req_addr_d              = '0;
      req_valid_d             = 1'b0;
      imem_req_o              = 1'b0;
      imem_addr_o             = '0;
      insn_fetch_resp_valid_o = 1'b0;
      insn_fetch_err_o        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pf_addr_q   <= '0;
      req_addr_q  <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pf_addr_q   <= pf_addr_d;
      req_addr_q  <= req_addr_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Instructions are word aligned; misaligned core requests are a protocol violation.
  req_addr_aligned_a : assert property (@(posedge clk_i) disable iff (rst_i)
      insn_fetch_req_valid_i |-> (insn_fetch_req_addr_i[1:0] == 2'b00));

  pf_addr_aligned_a : assert property (@(posedge clk_i) disable iff (rst_i)
      pf_addr_q[1:0] == 2'b00);

endmodule

// File: tb/tb_otbn_insn_prefetch.sv
// Directed bench for otbn_insn_prefetch: per-cycle stimulus rows with hand-derived
// expected fetch-port and response-port values, backed by a one-cycle-latency Imem.
`timescale 1ns/1ps
module tb_otbn_insn_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [11:0] imem_addr_o;
  logic [38:0] imem_rdata_i;
  logic        imem_rvalid_i;
  logic        insn_fetch_req_valid_i;
  logic [11:0] insn_fetch_req_addr_i;
  logic        insn_fetch_resp_valid_o;
  logic [11:0] insn_fetch_resp_addr_o;
  logic [31:0] insn_fetch_resp_data_o;
  logic        insn_fetch_err_o;
  logic        prefetch_loop_active_i;
  logic [31:0] prefetch_loop_iterations_i;
  logic [12:0] prefetch_loop_end_addr_i;
  logic [11:0] prefetch_loop_jump_addr_i;
  logic        stall_i;
  logic        clear_i;

  logic [38:0] flip_mask;
  logic        drop_rvalid;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        v;
    logic [11:0] a;
    logic        stall;
    logic        clr;
    logic        rst;
    logic [38:0] flip;
    logic        drop;
    logic [31:0] iter;
    logic [12:0] lend;
    logic        e_req;
    logic [11:0] e_ia;
    logic        e_rv;
    logic [11:0] e_ra;
    logic        e_err;
  } row_t;

  row_t rows[$];

  otbn_insn_prefetch #(.ImemAddrWidth(12), .ImemDataWidth(39)) dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .imem_req_o                 (imem_req_o),
    .imem_addr_o                (imem_addr_o),
    .imem_rdata_i               (imem_rdata_i),
    .imem_rvalid_i              (imem_rvalid_i),
    .insn_fetch_req_valid_i     (insn_fetch_req_valid_i),
    .insn_fetch_req_addr_i      (insn_fetch_req_addr_i),
    .insn_fetch_resp_valid_o    (insn_fetch_resp_valid_o),
    .insn_fetch_resp_addr_o     (insn_fetch_resp_addr_o),
    .insn_fetch_resp_data_o     (insn_fetch_resp_data_o),
    .insn_fetch_err_o           (insn_fetch_err_o),
    .prefetch_loop_active_i     (prefetch_loop_active_i),
    .prefetch_loop_iterations_i (prefetch_loop_iterations_i),
    .prefetch_loop_end_addr_i   (prefetch_loop_end_addr_i),
    .prefetch_loop_jump_addr_i  (prefetch_loop_jump_addr_i),
    .stall_i                    (stall_i),
    .clear_i                    (clear_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {20'hC0DE0, a};
  endfunction

  // Inverted-SECDED (39,32) encoder: check bit j is the parity of the data bits in its column set.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  c;
    m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    for (int j = 0; j < 7; j++) c[j] = ^(d & m[j]);
    return {c, d} ^ {7'h2A, 32'h0};
  endfunction

  // Imem with one-cycle read latency; flip_mask corrupts and drop_rvalid suppresses a response.
  always @(posedge clk_i) begin
    imem_rvalid_i <= imem_req_o & ~drop_rvalid;
    imem_rdata_i  <= imem_req_o ? (enc(mem_word(imem_addr_o)) ^ flip_mask) : 39'h0;
  end

  function automatic row_t mk(input logic v, input logic [11:0] a, input logic e_req,
                              input logic [11:0] e_ia, input logic e_rv,
                              input logic [11:0] e_ra, input logic e_err);
    row_t r;
    r.v = v;  r.a = a;  r.stall = 1'b0;  r.clr = 1'b0;  r.rst = 1'b0;
    r.flip = 39'h0;  r.drop = 1'b0;  r.iter = 32'd0;  r.lend = 13'h0;
    r.e_req = e_req;  r.e_ia = e_ia;  r.e_rv = e_rv;  r.e_ra = e_ra;  r.e_err = e_err;
    return r;
  endfunction

  function automatic string got_s();
    return $sformatf("req=%b ia=%h rv=%b err=%b ra=%h rd=%h", imem_req_o, imem_addr_o,
                     insn_fetch_resp_valid_o, insn_fetch_err_o, insn_fetch_resp_addr_o,
                     insn_fetch_resp_data_o);
  endfunction

  function automatic string want_s(input row_t r);
    return $sformatf("req=%b ia=%h rv=%b err=%b ra=%h rd=%h", r.e_req, r.e_ia, r.e_rv,
                     r.e_err, r.e_ra, mem_word(r.e_ra));
  endfunction

  // Applies one cycle of stimulus just after the edge and lets combinational outputs settle.
  task automatic drive(input row_t r);
    @(posedge clk_i);
    #1;
    insn_fetch_req_valid_i     = r.v;
    insn_fetch_req_addr_i      = r.a;
    stall_i                    = r.stall;
    clear_i                    = r.clr;
    rst_i                      = r.rst;
    flip_mask                  = r.flip;
    drop_rvalid                = r.drop;
    prefetch_loop_iterations_i = r.iter;
    prefetch_loop_end_addr_i   = r.lend;
    #1;
  endtask

  task automatic test_reset();
    row_t r;
    rows.delete();
    r = mk(0, 12'h0, 0, 12'h0, 0, 12'h0, 0); r.rst = 1'b1;
    rows.push_back(r);
    rows.push_back(r);
    rows.push_back(mk(0, 12'h0, 0, 12'h0, 0, 12'h0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_resp_addr_o,
           insn_fetch_resp_data_o, insn_fetch_err_o} !== 59'h0) begin
        n_fails++;
        $display("FAIL reset[%0d]: got %s, expected all outputs zero", i, got_s());
      end
    end
  endtask

  task automatic test_sequential();
    rows.delete();
    rows.push_back(mk(1, 12'h000, 1, 12'h000, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h004, 1, 12'h004, 1, 12'h000, 0));
    rows.push_back(mk(1, 12'h008, 1, 12'h008, 1, 12'h004, 0));
    rows.push_back(mk(1, 12'h00C, 1, 12'h00C, 1, 12'h008, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h00C, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_err_o} !==
          {rows[i].e_req, rows[i].e_ia, rows[i].e_rv, rows[i].e_err} ||
          (rows[i].e_rv && {insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !==
                           {rows[i].e_ra, mem_word(rows[i].e_ra)})) begin
        n_fails++;
        $display("FAIL seq[%0d]: got %s, expected %s", i, got_s(), want_s(rows[i]));
      end
    end
  endtask

  task automatic test_branch();
    rows.delete();
    rows.push_back(mk(1, 12'h004, 1, 12'h004, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h008, 1, 12'h008, 1, 12'h004, 0));
    rows.push_back(mk(1, 12'h100, 1, 12'h00C, 1, 12'h008, 0));
    rows.push_back(mk(1, 12'h100, 1, 12'h100, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h104, 1, 12'h104, 1, 12'h100, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h104, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_err_o} !==
          {rows[i].e_req, rows[i].e_ia, rows[i].e_rv, rows[i].e_err} ||
          (rows[i].e_rv && {insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !==
                           {rows[i].e_ra, mem_word(rows[i].e_ra)})) begin
        n_fails++;
        $display("FAIL branch[%0d]: got %s, expected %s", i, got_s(), want_s(rows[i]));
      end
    end
  endtask

  task automatic test_loop();
    row_t r;
    logic [31:0] iters [13];
    logic [12:0] ends  [13];
    iters = '{3, 3, 3, 3, 3, 1, 1, 1, 3, 3, 3, 3, 3};
    ends  = '{13'h010, 13'h010, 13'h010, 13'h010, 13'h010, 13'h010, 13'h010, 13'h010,
              13'h1010, 13'h1010, 13'h1010, 13'h1010, 13'h1010};
    prefetch_loop_active_i    = 1'b1;
    prefetch_loop_jump_addr_i = 12'h008;
    rows.delete();
    rows.push_back(mk(1, 12'h00C, 1, 12'h00C, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h010, 1, 12'h010, 1, 12'h00C, 0));
    rows.push_back(mk(1, 12'h008, 1, 12'h008, 1, 12'h010, 0));
    rows.push_back(mk(1, 12'h00C, 1, 12'h00C, 1, 12'h008, 0));
    rows.push_back(mk(1, 12'h010, 1, 12'h010, 1, 12'h00C, 0));
    rows.push_back(mk(1, 12'h014, 1, 12'h014, 1, 12'h010, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h014, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h00C, 1, 12'h00C, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h010, 1, 12'h010, 1, 12'h00C, 0));
    rows.push_back(mk(1, 12'h014, 1, 12'h014, 1, 12'h010, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h014, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    foreach (rows[i]) begin
      r = rows[i];
      r.iter = iters[i];
      r.lend = ends[i];
      drive(r);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_err_o} !==
          {r.e_req, r.e_ia, r.e_rv, r.e_err} ||
          (r.e_rv && {insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !==
                     {r.e_ra, mem_word(r.e_ra)})) begin
        n_fails++;
        $display("FAIL loop[%0d]: got %s, expected %s", i, got_s(), want_s(r));
      end
    end
    prefetch_loop_active_i    = 1'b0;
    prefetch_loop_jump_addr_i = 12'h000;
  endtask

  task automatic test_stall();
    row_t r;
    rows.delete();
    rows.push_back(mk(1, 12'h01C, 1, 12'h01C, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h020, 1, 12'h020, 1, 12'h01C, 0));
    for (int k = 0; k < 3; k++) begin
      r = mk(1, 12'h020, 1, 12'h020, 1, 12'h020, 0);
      r.stall = 1'b1;
      rows.push_back(r);
    end
    rows.push_back(mk(1, 12'h024, 1, 12'h024, 1, 12'h020, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h024, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_err_o} !==
          {rows[i].e_req, rows[i].e_ia, rows[i].e_rv, rows[i].e_err} ||
          (rows[i].e_rv && {insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !==
                           {rows[i].e_ra, mem_word(rows[i].e_ra)})) begin
        n_fails++;
        $display("FAIL stall[%0d]: got %s, expected %s", i, got_s(), want_s(rows[i]));
      end
    end
  endtask

  task automatic test_integrity();
    row_t r;
    rows.delete();
    r = mk(1, 12'h030, 1, 12'h030, 0, 12'h000, 0); r.flip = 39'h1 << 35;
    rows.push_back(r);
    rows.push_back(mk(1, 12'h034, 1, 12'h034, 1, 12'h030, 1));
    r = mk(1, 12'h038, 1, 12'h038, 1, 12'h034, 0); r.flip = (39'h1 << 33) | (39'h1 << 37);
    rows.push_back(r);
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h038, 1));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_err_o} !==
          {rows[i].e_req, rows[i].e_ia, rows[i].e_rv, rows[i].e_err} ||
          (rows[i].e_rv && {insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !==
                           {rows[i].e_ra, mem_word(rows[i].e_ra)})) begin
        n_fails++;
        $display("FAIL ecc[%0d]: got %s, expected %s", i, got_s(), want_s(rows[i]));
      end
    end
  endtask

  task automatic test_rvalid_gap();
    row_t r;
    rows.delete();
    r = mk(1, 12'h050, 1, 12'h050, 0, 12'h000, 0); r.drop = 1'b1;
    rows.push_back(r);
    rows.push_back(mk(1, 12'h050, 1, 12'h050, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h054, 1, 12'h054, 1, 12'h050, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h054, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_err_o} !==
          {rows[i].e_req, rows[i].e_ia, rows[i].e_rv, rows[i].e_err} ||
          (rows[i].e_rv && {insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !==
                           {rows[i].e_ra, mem_word(rows[i].e_ra)})) begin
        n_fails++;
        $display("FAIL rvalid[%0d]: got %s, expected %s", i, got_s(), want_s(rows[i]));
      end
    end
  endtask

  task automatic test_clear_reset();
    row_t r;
    rows.delete();
    rows.push_back(mk(1, 12'h060, 1, 12'h060, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h064, 1, 12'h064, 1, 12'h060, 0));
    r = mk(1, 12'h068, 0, 12'h000, 0, 12'h000, 0); r.clr = 1'b1;
    rows.push_back(r);
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h070, 1, 12'h070, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h074, 1, 12'h074, 1, 12'h070, 0));
    r = mk(1, 12'h078, 0, 12'h000, 0, 12'h000, 0); r.rst = 1'b1;
    rows.push_back(r);
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h040, 1, 12'h040, 0, 12'h000, 0));
    rows.push_back(mk(1, 12'h044, 1, 12'h044, 1, 12'h040, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 1, 12'h044, 0));
    rows.push_back(mk(0, 12'h000, 0, 12'h000, 0, 12'h000, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      n_checks++;
      if ({imem_req_o, imem_addr_o, insn_fetch_resp_valid_o, insn_fetch_err_o} !==
          {rows[i].e_req, rows[i].e_ia, rows[i].e_rv, rows[i].e_err} ||
          (rows[i].e_rv && {insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !==
                           {rows[i].e_ra, mem_word(rows[i].e_ra)})) begin
        n_fails++;
        $display("FAIL clear[%0d]: got %s, expected %s", i, got_s(), want_s(rows[i]));
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if ({insn_fetch_resp_addr_o, insn_fetch_resp_data_o} !== 44'h0) begin
          n_fails++;
          $display("FAIL clear_zero[%0d]: got ra=%h rd=%h, expected ra=000 rd=00000000",
                   i, insn_fetch_resp_addr_o, insn_fetch_resp_data_o);
        end
      end
    end
  endtask

  initial begin
    rst_i                      = 1'b1;
    insn_fetch_req_valid_i     = 1'b0;
    insn_fetch_req_addr_i      = 12'h0;
    prefetch_loop_active_i     = 1'b0;
    prefetch_loop_iterations_i = 32'd0;
    prefetch_loop_end_addr_i   = 13'h0;
    prefetch_loop_jump_addr_i  = 12'h0;
    stall_i                    = 1'b0;
    clear_i                    = 1'b0;
    flip_mask                  = 39'h0;
    drop_rvalid                = 1'b0;

    test_reset();
    test_sequential();
    test_branch();
    test_loop();
    test_stall();
    test_integrity();
    test_rvalid_gap();
    test_clear_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
